// File: rtl/inst_fetch_queue.sv
// Fetch stage: issues sequential PCs to imem, tags them, and queues in-order responses for decode.
// Optional IF_MISALIGN_CHK_EN: flags non-word-aligned jump targets and stalls fetch until reset.
module inst_fetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_flag,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [INST_W-1:0] inst,
  output logic              misalign
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  entry_t            fifo_q [DEPTH];
  logic [ADDR_W-1:0] tag_q  [DEPTH];
  logic [PW-1:0]     f_wr, f_rd, t_wr, t_rd;
  logic [CW-1:0]     fifo_cnt, outst, drop_cnt;
  logic [ADDR_W-1:0] fetch_pc;
  logic              mis_q;
  logic              credit, issue, rsp_keep, rsp_drop, pop;

`ifdef IF_MISALIGN_CHK_EN
  always_ff @(posedge clk or posedge rst)
    if (rst)                                         mis_q <= 1'b0;
    else if (jump_flag && (jump_addr[1:0] != 2'b00)) mis_q <= 1'b1;
`else
  assign mis_q = 1'b0;
`endif
  assign misalign = mis_q;

  // Every issued request owns a FIFO slot, so a kept response always finds room.
  assign credit   = ({1'b0, fifo_cnt} + {1'b0, outst}) < (CW+1)'(DEPTH);
  assign imem_req = ~rst & ~jump_flag & ~mis_q & credit;
  assign imem_addr = fetch_pc;
  assign issue    = imem_req & imem_gnt;
  assign rsp_drop = imem_rvalid & (drop_cnt != '0);
  assign rsp_keep = imem_rvalid & (drop_cnt == '0) & ~jump_flag;

  assign inst_valid = (fifo_cnt != '0);
  assign pop        = inst_valid & inst_ready & ~jump_flag;
  assign inst_pc    = inst_valid ? fifo_q[f_rd].pc   : '0;
  assign inst       = inst_valid ? fifo_q[f_rd].inst : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      fifo_cnt <= '0;
      outst    <= '0;
      drop_cnt <= '0;
      f_wr     <= '0;
      f_rd     <= '0;
      t_wr     <= '0;
      t_rd     <= '0;
    end else if (jump_flag) begin
      // Everything in flight becomes stale; a response landing now is one of them.
      fetch_pc <= jump_addr;
      fifo_cnt <= '0;
      outst    <= '0;
      drop_cnt <= drop_cnt + outst - CW'(imem_rvalid);
      f_wr     <= '0;
      f_rd     <= '0;
      t_wr     <= '0;
      t_rd     <= '0;
    end else begin
      if (issue) begin
        fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
        t_wr     <= t_wr + 1'b1;
      end
      if (rsp_keep) begin
        t_rd <= t_rd + 1'b1;
        f_wr <= f_wr + 1'b1;
      end
      if (pop)      f_rd     <= f_rd + 1'b1;
      if (rsp_drop) drop_cnt <= drop_cnt - 1'b1;
      fifo_cnt <= fifo_cnt + CW'(rsp_keep) - CW'(pop);
      outst    <= outst + CW'(issue) - CW'(rsp_keep);
    end
  end

  always_ff @(posedge clk) begin
    if (issue)    tag_q[t_wr]  <= fetch_pc;
    if (rsp_keep) fifo_q[f_wr] <= '{pc: tag_q[t_rd], inst: imem_rdata};
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    rsp_keep |-> (fifo_cnt != CW'(DEPTH)));

endmodule
